// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-store buffer and the data memory.
package store_buffer_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned FUNCT3_W = 3;
   localparam int unsigned IDX_LSB  = 2;
   localparam int unsigned IDX_MSB  = 11;
   localparam int unsigned IDX_W    = IDX_MSB - IDX_LSB + 1;

   localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
   localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
   localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
   localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
   localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   data;
      logic [FUNCT3_W-1:0] funct3;
   } sb_entry_t;

   // Narrow a word to the load width and sign- or zero-extend it.
   function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                     input logic [FUNCT3_W-1:0] f3);
      logic [DATA_W-1:0] r;
      case (f3)
         F3_B:    r = {{24{d[7]}}, d[7:0]};
         F3_H:    r = {{16{d[15]}}, d[15:0]};
         F3_BU:   r = {24'h0, d[7:0]};
         F3_HU:   r = {16'h0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load handshake and data-memory port of the store buffer.
interface store_buffer_if;
   import store_buffer_pkg::*;

   logic                st_valid;
   logic                st_ready;
   logic [ADDR_W-1:0]   st_addr;
   logic [DATA_W-1:0]   st_data;
   logic [FUNCT3_W-1:0] st_funct3;
   logic                ld_valid;
   logic [ADDR_W-1:0]   ld_addr;
   logic [FUNCT3_W-1:0] ld_funct3;
   logic                ld_stall;
   logic                ld_fwd_valid;
   logic [DATA_W-1:0]   ld_fwd_data;
   logic                mem_write;
   logic                mem_read;
   logic [ADDR_W-1:0]   mem_address;
   logic [DATA_W-1:0]   mem_write_data;
   logic [FUNCT3_W-1:0] mem_funct3;
   logic                empty;

   modport master (
      output st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, ld_funct3,
      input  st_ready, ld_stall, ld_fwd_valid, ld_fwd_data, mem_write, mem_read,
             mem_address, mem_write_data, mem_funct3, empty
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, ld_funct3,
      output st_ready, ld_stall, ld_fwd_valid, ld_fwd_data, mem_write, mem_read,
             mem_address, mem_write_data, mem_funct3, empty
   );

endinterface

// File: rtl/sb_match.sv
// Combinational search of the valid buffer entries for a load's word index; newest hit wins.
module sb_match
   import store_buffer_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic [DEPTH-1:0][IDX_W-1:0] widx,
   input  logic [DEPTH-1:0]            is_word,
   input  logic [PTR_W-1:0]            head,
   input  logic [CNT_W-1:0]            count,
   input  logic [IDX_W-1:0]            ld_widx,
   output logic                        hit_c,
   output logic [PTR_W-1:0]            hit_idx_c,
   output logic                        hit_fwd_c
);

   // Walk oldest to newest so the last hit seen is the newest one.
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      hit_fwd_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) && (widx[head + PTR_W'(i)] == ld_widx)) begin
            hit_c     = 1'b1;
            hit_idx_c = head + PTR_W'(i);
            hit_fwd_c = is_word[head + PTR_W'(i)];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO sharing one data-memory port with loads.
// Define SB_FORWARD_EN to forward buffered full-word stores to matching loads.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   store_buffer_if.slave sb
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
`ifdef SB_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   sb_entry_t [DEPTH-1:0]        entries_q, entries_d;
   logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]             count_q, count_d;

   logic [DEPTH-1:0][IDX_W-1:0]  widx;
   logic [DEPTH-1:0]             is_word;
   logic                         hit, hit_fwd;
   logic [PTR_W-1:0]             hit_idx;

   logic                         full_buf, st_ready_c, enq, ld_go, fwd, rd, drain;
   logic                         ld_stall_c, fwd_valid_c;
   logic [DATA_W-1:0]            fwd_data_c, mem_wdata_c;
   logic                         mem_write_c, mem_read_c;
   logic [ADDR_W-1:0]            mem_addr_c;
   logic [FUNCT3_W-1:0]          mem_f3_c;

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         widx[i]    = entries_q[i].addr[IDX_MSB:IDX_LSB];
         is_word[i] = (entries_q[i].funct3 == F3_W);
      end
   end

   sb_match #(.DEPTH(DEPTH)) u_match (
      .widx      (widx),
      .is_word   (is_word),
      .head      (head_q),
      .count     (count_q),
      .ld_widx   (sb.ld_addr[IDX_MSB:IDX_LSB]),
      .hit_c     (hit),
      .hit_idx_c (hit_idx),
      .hit_fwd_c (hit_fwd)
   );

   // Port arbitration: a memory load blocks the drain; forward, hazard and full leave it free.
   always_comb begin
      full_buf    = (count_q == CNT_W'(DEPTH));
      st_ready_c  = !full_buf && rst_n;
      enq         = sb.st_valid && st_ready_c;
      ld_go       = sb.ld_valid && rst_n;
      fwd         = ld_go && hit && hit_fwd && FWD_EN;
      rd          = ld_go && !hit && !full_buf;
      drain       = !rd && (count_q != '0) && rst_n;
      // A same-cycle store is older than the load, so the load waits even if data is at hand.
      ld_stall_c  = ld_go && ((hit && !fwd) || (!hit && full_buf) || sb.st_valid);
      fwd_valid_c = fwd && !sb.st_valid;
      fwd_data_c  = '0;
      if (fwd_valid_c) fwd_data_c = load_extend(entries_q[hit_idx].data, sb.ld_funct3);

      mem_write_c = 1'b0;
      mem_read_c  = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      mem_f3_c    = '0;
      if (rd) begin
         mem_read_c = 1'b1;
         mem_addr_c = sb.ld_addr;
         mem_f3_c   = sb.ld_funct3;
      end else if (drain) begin
         mem_write_c = 1'b1;
         mem_addr_c  = entries_q[head_q].addr;
         mem_wdata_c = entries_q[head_q].data;
         mem_f3_c    = entries_q[head_q].funct3;
      end
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      if (enq) begin
         entries_d[tail_q] = '{addr: sb.st_addr, data: sb.st_data, funct3: sb.st_funct3};
         tail_d            = tail_q + PTR_W'(1);
      end
      if (drain) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   assign sb.st_ready       = st_ready_c;
   assign sb.ld_stall       = ld_stall_c;
   assign sb.ld_fwd_valid   = fwd_valid_c;
   assign sb.ld_fwd_data    = fwd_data_c;
   assign sb.mem_write      = mem_write_c;
   assign sb.mem_read       = mem_read_c;
   assign sb.mem_address    = mem_addr_c;
   assign sb.mem_write_data = mem_wdata_c;
   assign sb.mem_funct3     = mem_f3_c;
   assign sb.empty          = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int unsigned DEPTH = 4;
`ifdef SB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_if sbi ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sbi)
   );

   int        total = 0;
   int        bad   = 0;
   sb_entry_t mq[$];
   logic      pend_drain = 1'b0;
   logic      pend_enq   = 1'b0;
   sb_entry_t pend_entry;
   logic      exp_stall  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] f);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = d[7:0];
      h = d[15:0];
      case (f)
         F3_B:    return 32'(b);
         F3_H:    return 32'(h);
         F3_BU:   return d & 32'h0000_00FF;
         F3_HU:   return d & 32'h0000_FFFF;
         default: return d;
      endcase
   endfunction

   // Reference model: evaluate the port for this cycle from the queue and compare every output.
   always @(negedge clk) begin : cmp
      logic        e_rdy, e_stall, e_fv, e_mw, e_mr, e_empty, busy;
      logic [31:0] e_fd, e_ma, e_mwd;
      logic [2:0]  e_mf;
      int          m;
      e_rdy = 0; e_stall = 0; e_fv = 0; e_mw = 0; e_mr = 0; e_empty = 1; busy = 0;
      e_fd = 0; e_ma = 0; e_mwd = 0; e_mf = 0;
      pend_drain = 0;
      pend_enq   = 0;
      if (!rst_n) begin
         mq.delete();
      end else begin
         m = -1;
         for (int i = 0; i < mq.size(); i++)
            if (mq[i].addr[11:2] == sbi.ld_addr[11:2]) m = i;
         e_rdy   = (mq.size() < int'(DEPTH));
         e_empty = (mq.size() == 0);
         if (sbi.ld_valid) begin
            if (m >= 0 && FWD && mq[m].funct3 == F3_W) begin
               if (sbi.st_valid) e_stall = 1;
               else begin
                  e_fv = 1;
                  e_fd = ext(mq[m].data, sbi.ld_funct3);
               end
            end else if (m >= 0 || mq.size() == int'(DEPTH)) begin
               e_stall = 1;
            end else begin
               busy    = 1;
               e_mr    = 1;
               e_ma    = sbi.ld_addr;
               e_mf    = sbi.ld_funct3;
               e_stall = sbi.st_valid;
            end
         end
         if (!busy && mq.size() > 0) begin
            e_mw = 1;
            e_ma = mq[0].addr;
            e_mwd = mq[0].data;
            e_mf = mq[0].funct3;
            pend_drain = 1;
         end
         if (sbi.st_valid && e_rdy) begin
            pend_enq   = 1;
            pend_entry = '{addr: sbi.st_addr, data: sbi.st_data, funct3: sbi.st_funct3};
         end
      end
      exp_stall = e_stall;
      chk("st_ready",       32'(sbi.st_ready),     32'(e_rdy));
      chk("ld_stall",       32'(sbi.ld_stall),     32'(e_stall));
      chk("ld_fwd_valid",   32'(sbi.ld_fwd_valid), 32'(e_fv));
      chk("ld_fwd_data",    sbi.ld_fwd_data,       e_fd);
      chk("mem_write",      32'(sbi.mem_write),    32'(e_mw));
      chk("mem_read",       32'(sbi.mem_read),     32'(e_mr));
      chk("mem_address",    sbi.mem_address,       e_ma);
      chk("mem_write_data", sbi.mem_write_data,    e_mwd);
      chk("mem_funct3",     32'(sbi.mem_funct3),   32'(e_mf));
      chk("empty",          32'(sbi.empty),        32'(e_empty));
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (pend_drain) void'(mq.pop_front());
         if (pend_enq) mq.push_back(pend_entry);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      sbi.st_valid  = 0; sbi.st_addr = 0; sbi.st_data = 0; sbi.st_funct3 = 0;
      sbi.ld_valid  = 0; sbi.ld_addr = 0; sbi.ld_funct3 = 0;
   endtask

   task automatic put_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      sbi.st_valid = 1; sbi.st_addr = a; sbi.st_data = d; sbi.st_funct3 = f;
   endtask

   task automatic put_ld(input logic [31:0] a, input logic [2:0] f);
      sbi.ld_valid = 1; sbi.ld_addr = a; sbi.ld_funct3 = f;
   endtask

   // Wait (bounded) for a held load to be released; the wait must not exceed DEPTH cycles.
   task automatic wait_go(input string name);
      int n;
      n = 0;
      while (sbi.ld_stall === 1'b1 && n <= int'(DEPTH)) begin
         nxt();
         smp();
         n++;
      end
      chk(name, 32'(sbi.ld_stall), 32'h0);
      chk({name, "_bound"}, 32'(n <= int'(DEPTH)), 32'h1);
   endtask

   function automatic logic [31:0] raddr(input logic [2:0] f);
      logic [31:0] a;
      a = 32'h1000 * $urandom_range(0, 1) + 32'h40 + 32'h4 * $urandom_range(0, 5);
      if (f == F3_B || f == F3_BU) a = a + 32'($urandom_range(0, 3));
      else if (f == F3_H || f == F3_HU) a = a + 32'h2 * $urandom_range(0, 1);
      return a;
   endfunction

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [2:0] lf[5];
      logic [2:0] sf[3];
      lf = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
      sf = '{F3_B, F3_H, F3_W};
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      smp();
      chk("rst_st_ready",  32'(sbi.st_ready),  32'h0);
      chk("rst_empty",     32'(sbi.empty),     32'h1);
      chk("rst_mem_write", 32'(sbi.mem_write), 32'h0);
      chk("rst_ld_stall",  32'(sbi.ld_stall),  32'h0);
      nxt();
      rst_n = 1;

      // basic drain
      put_st(32'h100, 32'hDEAD_BEEF, F3_W);
      smp();
      chk("drain_ready", 32'(sbi.st_ready), 32'h1);
      chk("drain_not_yet", 32'(sbi.mem_write), 32'h0);
      nxt(); idle();
      smp();
      chk("drain_write", 32'(sbi.mem_write), 32'h1);
      chk("drain_addr",  sbi.mem_address, 32'h100);
      chk("drain_data",  sbi.mem_write_data, 32'hDEAD_BEEF);
      chk("drain_f3",    32'(sbi.mem_funct3), 32'h2);
      nxt();
      smp();
      chk("drain_empty", 32'(sbi.empty), 32'h1);

      // full-word forward
      nxt(); put_st(32'h200, 32'h80FF_1234, F3_W);
      nxt(); idle(); put_ld(32'h200, F3_B);
      smp();
`ifdef SB_FORWARD_EN
      chk("fwd_valid", 32'(sbi.ld_fwd_valid), 32'h1);
      chk("fwd_lb",    sbi.ld_fwd_data, 32'h0000_0034);
      chk("fwd_stall", 32'(sbi.ld_stall), 32'h0);
      #1 sbi.ld_funct3 = F3_HU;
      #1 chk("fwd_lhu", sbi.ld_fwd_data, 32'h0000_1234);
`else
      chk("nofwd_stall", 32'(sbi.ld_stall), 32'h1);
      chk("nofwd_valid", 32'(sbi.ld_fwd_valid), 32'h0);
      wait_go("nofwd_go");
`endif

      // partial hazard
      nxt(); idle(); put_st(32'h300, 32'h0000_00AA, F3_B);
      nxt(); idle(); put_ld(32'h300, F3_W);
      smp();
      chk("haz_stall", 32'(sbi.ld_stall), 32'h1);
      chk("haz_drain_addr", sbi.mem_address, 32'h300);
      chk("haz_drain_f3", 32'(sbi.mem_funct3), 32'h0);
      wait_go("haz_go");
      chk("haz_read", 32'(sbi.mem_read), 32'h1);
      chk("haz_read_addr", sbi.mem_address, 32'h300);

      // fill the buffer behind a non-matching load that owns the port
      nxt(); idle(); put_ld(32'h800, F3_W);
      for (int i = 0; i < int'(DEPTH); i++) begin
         put_st(32'h500 + 32'(4 * i), 32'h1000 + 32'(i), F3_W);
         nxt();
      end
      put_st(32'h600, 32'h77, F3_W);
      smp();
      chk("full_ready", 32'(sbi.st_ready), 32'h0);
      chk("full_stall", 32'(sbi.ld_stall), 32'h1);
      chk("full_drain", 32'(sbi.mem_write), 32'h1);
      chk("full_drain_addr", sbi.mem_address, 32'h500);
      nxt();
      smp();
      chk("full_ready_back", 32'(sbi.st_ready), 32'h1);
      nxt(); sbi.st_valid = 0;
      smp();
      wait_go("full_go");
      chk("full_read", 32'(sbi.mem_read), 32'h1);
      nxt(); idle();
      repeat (DEPTH + 2) nxt();
      smp();
      chk("full_empty", 32'(sbi.empty), 32'h1);

      // pointer wrap over 3*DEPTH back-to-back stores
      nxt();
      for (int i = 0; i < 3 * int'(DEPTH); i++) begin
         put_st(32'h700 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), F3_W);
         nxt();
      end
      idle();
      smp();
      chk("wrap_last", sbi.mem_write_data, 32'hC0DE_0000 + 32'(3 * DEPTH - 1));
      repeat (2) nxt();

      // newest match wins
      put_ld(32'h800, F3_W);
      put_st(32'h400, 32'h1, F3_W); nxt();
      put_st(32'h400, 32'h2, F3_W); nxt();
      idle(); put_ld(32'h400, F3_W);
      smp();
`ifdef SB_FORWARD_EN
      chk("newest_valid", 32'(sbi.ld_fwd_valid), 32'h1);
      chk("newest_data",  sbi.ld_fwd_data, 32'h2);
`else
      chk("newest_stall", 32'(sbi.ld_stall), 32'h1);
`endif
      nxt(); idle();
      repeat (DEPTH + 2) nxt();

      // reset with three pending stores
      put_ld(32'h800, F3_W);
      for (int i = 0; i < 3; i++) begin
         put_st(32'h900 + 32'(4 * i), 32'(i), F3_W);
         nxt();
      end
      idle();
      rst_n = 0;
      smp();
      chk("rst_mid_empty", 32'(sbi.empty), 32'h1);
      chk("rst_mid_write", 32'(sbi.mem_write), 32'h0);
      nxt(); nxt();
      rst_n = 1;
      smp();
      chk("post_rst_empty", 32'(sbi.empty), 32'h1);
      chk("post_rst_write", 32'(sbi.mem_write), 32'h0);

      // random traffic; stalled loads are held, occasional reset pulses
      for (int c = 0; c < 3000; c++) begin
         nxt();
         rst_n = ($urandom_range(0, 399) != 0);
         if (!(sbi.ld_valid && exp_stall)) begin
            sbi.ld_valid  = ($urandom_range(0, 1) == 1);
            sbi.ld_funct3 = lf[$urandom_range(0, 4)];
            sbi.ld_addr   = raddr(sbi.ld_funct3);
         end
         sbi.st_valid  = ($urandom_range(0, 2) == 0);
         sbi.st_funct3 = sf[$urandom_range(0, 2)];
         sbi.st_addr   = raddr(sbi.st_funct3);
         sbi.st_data   = $urandom;
      end
      nxt(); idle(); rst_n = 1;
      repeat (DEPTH + 2) nxt();
      smp();
      chk("final_empty", 32'(sbi.empty), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
